// File: rtl/buzzer_tone_driver.sv
// buzzer_tone_driver: turns the highest-priority zone request into a zone-pitched square wave.
//
// Optional feature macro: BUZZ_CADENCE_EN. When it is defined, the tone is chopped into
// ON_CYCLES-long audible bursts separated by OFF_CYCLES of silence (GAP state).
//
// Ports:
//   clk         - clock
//   rst_n       - synchronous active-low reset, has priority over ena
//   ena         - clock enable; when low all state and outputs hold
//   buzz_req    - level requests, bit k-1 requests zone k (3 > 2 > 1)
//   tone_out    - registered square wave for the buzzer pin
//   tone_active - high while not IDLE
//   zone        - active zone 1..3, 0 when IDLE
//   alarm_count - saturating count of IDLE->TONE entries
module buzzer_tone_driver #(
    parameter int unsigned HALF1      = 12,
    parameter int unsigned HALF2      = 8,
    parameter int unsigned HALF3      = 5,
    parameter int unsigned ON_CYCLES  = 48,
    parameter int unsigned OFF_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] buzz_req,
    output logic       tone_out,
    output logic       tone_active,
    output logic [1:0] zone,
    output logic [7:0] alarm_count
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TONE = 2'd1;
    localparam logic [7:0] H1_M1  = 8'(HALF1 - 1);
    localparam logic [7:0] H2_M1  = 8'(HALF2 - 1);
    localparam logic [7:0] H3_M1  = 8'(HALF3 - 1);
`ifdef BUZZ_CADENCE_EN
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [7:0] ON_M1  = 8'(ON_CYCLES - 1);
    localparam logic [7:0] OFF_M1 = 8'(OFF_CYCLES - 1);
    logic [7:0] cad_q, cad_d;
`endif
    logic [1:0] state_q, state_d;
    logic [1:0] zone_q, zone_d;
    logic       tone_q, tone_d;
    logic [7:0] div_q, div_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] sel;
    logic [7:0] half_m1;

    assign sel = buzz_req[2] ? 2'd3 : buzz_req[1] ? 2'd2 : buzz_req[0] ? 2'd1 : 2'd0;
    assign half_m1 = (zone_q == 2'd1) ? H1_M1 : (zone_q == 2'd2) ? H2_M1 : H3_M1;

    // zone_q is 0 in IDLE, so "sel differs from zone" covers both entry and zone change.
    always_comb begin
        state_d = state_q;
        zone_d  = zone_q;
        tone_d  = tone_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
`ifdef BUZZ_CADENCE_EN
        cad_d   = cad_q;
`endif
        if (sel == 2'd0) begin
            state_d = S_IDLE;
            tone_d  = 1'b0;
            zone_d  = 2'd0;
        end else if (sel != zone_q) begin
            state_d = S_TONE;
            zone_d  = sel;
            tone_d  = 1'b1;
            div_d   = 8'd0;
`ifdef BUZZ_CADENCE_EN
            cad_d   = 8'd0;
`endif
            if (state_q == S_IDLE && cnt_q != 8'hFF)
                cnt_d = cnt_q + 8'd1;
        end else if (state_q == S_TONE) begin
`ifdef BUZZ_CADENCE_EN
            cad_d = cad_q + 8'd1;
            if (cad_q == ON_M1) begin
                state_d = S_GAP;
                tone_d  = 1'b0;
                cad_d   = 8'd0;
            end else
`endif
            if (div_q == half_m1) begin
                tone_d = ~tone_q;
                div_d  = 8'd0;
            end else begin
                div_d  = div_q + 8'd1;
            end
        end
`ifdef BUZZ_CADENCE_EN
        else begin
            cad_d = cad_q + 8'd1;
            if (cad_q == OFF_M1) begin
                state_d = S_TONE;
                tone_d  = 1'b1;
                div_d   = 8'd0;
                cad_d   = 8'd0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            zone_q  <= 2'd0;
            tone_q  <= 1'b0;
            div_q   <= 8'd0;
            cnt_q   <= 8'd0;
`ifdef BUZZ_CADENCE_EN
            cad_q   <= 8'd0;
`endif
        end else if (ena) begin
            state_q <= state_d;
            zone_q  <= zone_d;
            tone_q  <= tone_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
`ifdef BUZZ_CADENCE_EN
            cad_q   <= cad_d;
`endif
        end
    end

    assign tone_out    = tone_q;
    assign tone_active = (state_q != S_IDLE);
    assign zone        = zone_q;
    assign alarm_count = cnt_q;
endmodule
